sia_wb_arbiter: RTL and testbench

Two-master arbiter that shares the single Wishbone B.4 pipelined slave port of the SIA (sia_wb) between the CPU and a second requester, such as a debug monitor or DMA engine.
- Grants the bus for the whole of a master's CYC assertion.
- Alternates priority round-robin on simultaneous requests.
- Tracks outstanding pipelined transfers, so acks are routed to the correct master and the slave is never over-committed.

---
 rtl/sia_wb_arbiter_pkg.sv | 17 +
 rtl/sia_wb_arb_cnt.sv | 42 ++++
 rtl/sia_wb_arbiter.sv | 137 +++++++++++++
 tb/tb_sia_wb_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sia_wb_arbiter_pkg.sv
// Shared definitions for the SIA Wishbone arbiter: grant state encodings and
// SIA register address map.
package sia_wb_arbiter_pkg;

  // The encodings double as the one-hot grant vector driven on gnt_o.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StG0   = 2'b01,
    StG1   = 2'b10
  } arb_state_e;

  localparam logic [3:1] SiaAdrCtrl   = 3'd0;
  localparam logic [3:1] SiaAdrConfig = 3'd1;
  localparam logic [3:1] SiaAdrStatus = 3'd2;
  localparam logic [3:1] SiaAdrData   = 3'd3;

endpackage

// File: rtl/sia_wb_arb_cnt.sv
// Outstanding-transfer counter: up on accepted strobe, down on ack, saturating
// at MAX_OUTST, never underflowing, with a synchronous clear.
module sia_wb_arb_cnt #(
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             limit_o
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_OUTST);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign limit_o = (cnt_q == CntMax);

endmodule

// File: rtl/sia_wb_arbiter.sv
// Two-master round-robin arbiter in front of the SIA Wishbone B.4 pipelined
// slave port; holds the grant for a whole CYC and routes acks to the owner.
module sia_wb_arbiter
  import sia_wb_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned CNT_W     = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:1]  m0_adr_i,
  input  logic [15:0] m0_dat_i,
  input  logic [1:0]  m0_sel_i,
  output logic [15:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_stall_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:1]  m1_adr_i,
  input  logic [15:0] m1_dat_i,
  input  logic [1:0]  m1_sel_i,
  output logic [15:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_stall_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:1]  s_adr_o,
  output logic [15:0] s_dat_o,
  output logic [1:0]  s_sel_o,
  input  logic [15:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_stall_i,
  output logic [1:0]  gnt_o
);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] outst;
  logic             limit;
  logic             cnt_inc, cnt_dec, cnt_clr;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Grant switches always pass through IDLE, so every grant lasts a full CYC.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
          state_d = StG0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = StG1;
          last_d  = 1'b1;
        end
      end
      StG0: if (!m0_cyc_i) state_d = StIdle;
      StG1: if (!m1_cyc_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_adr_o    = '0;
    s_dat_o    = '0;
    s_sel_o    = '0;
    m0_dat_o   = '0;
    m0_ack_o   = 1'b0;
    m0_stall_o = 1'b1;
    m1_dat_o   = '0;
    m1_ack_o   = 1'b0;
    m1_stall_o = 1'b1;
    unique case (state_q)
      StG0: begin
        s_cyc_o    = m0_cyc_i;
        s_stb_o    = m0_stb_i & ~limit;
        s_we_o     = m0_we_i;
        s_adr_o    = m0_adr_i;
        s_dat_o    = m0_dat_i;
        s_sel_o    = m0_sel_i;
        m0_stall_o = s_stall_i | limit;
        m0_ack_o   = s_ack_i & m0_cyc_i;
        m0_dat_o   = s_dat_i;
      end
      StG1: begin
        s_cyc_o    = m1_cyc_i;
        s_stb_o    = m1_stb_i & ~limit;
        s_we_o     = m1_we_i;
        s_adr_o    = m1_adr_i;
        s_dat_o    = m1_dat_i;
        s_sel_o    = m1_sel_i;
        m1_stall_o = s_stall_i | limit;
        m1_ack_o   = s_ack_i & m1_cyc_i;
        m1_dat_o   = s_dat_i;
      end
      default: ;
    endcase
  end

  assign gnt_o = state_q;

  // Acks seen while no CYC is driven belong to an aborted cycle and are dropped.
  assign cnt_inc = s_stb_o & ~s_stall_i;
  assign cnt_dec = s_ack_i & s_cyc_o;
  assign cnt_clr = (state_q != StIdle) && (state_d == StIdle);

  sia_wb_arb_cnt #(
    .MAX_OUTST (MAX_OUTST),
    .CNT_W     (CNT_W)
  ) u_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (cnt_inc),
    .dec_i   (cnt_dec),
    .clr_i   (cnt_clr),
    .cnt_o   (outst),
    .limit_o (limit)
  );

endmodule

// File: tb/tb_sia_wb_arbiter.sv
// Self-checking bench for sia_wb_arbiter: directed scenarios, a simple
// latency-programmable slave model and an ack scoreboard.
module tb_sia_wb_arbiter;
  import sia_wb_arbiter_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [3:1]  m0_adr_i = '0;
  logic [15:0] m0_dat_i = '0;
  logic [1:0]  m0_sel_i = '0;
  logic [15:0] m0_dat_o;
  logic        m0_ack_o, m0_stall_o;
  logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [3:1]  m1_adr_i = '0;
  logic [15:0] m1_dat_i = '0;
  logic [1:0]  m1_sel_i = '0;
  logic [15:0] m1_dat_o;
  logic        m1_ack_o, m1_stall_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:1]  s_adr_o;
  logic [15:0] s_dat_o;
  logic [1:0]  s_sel_o;
  logic [15:0] s_dat_i;
  logic        s_ack_i;
  logic        s_stall_i = 1'b0;
  logic [1:0]  gnt_o;

  sia_wb_arbiter #(
    .MAX_OUTST (2),
    .CNT_W     (3)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .m0_cyc_i   (m0_cyc_i),
    .m0_stb_i   (m0_stb_i),
    .m0_we_i    (m0_we_i),
    .m0_adr_i   (m0_adr_i),
    .m0_dat_i   (m0_dat_i),
    .m0_sel_i   (m0_sel_i),
    .m0_dat_o   (m0_dat_o),
    .m0_ack_o   (m0_ack_o),
    .m0_stall_o (m0_stall_o),
    .m1_cyc_i   (m1_cyc_i),
    .m1_stb_i   (m1_stb_i),
    .m1_we_i    (m1_we_i),
    .m1_adr_i   (m1_adr_i),
    .m1_dat_i   (m1_dat_i),
    .m1_sel_i   (m1_sel_i),
    .m1_dat_o   (m1_dat_o),
    .m1_ack_o   (m1_ack_o),
    .m1_stall_o (m1_stall_o),
    .s_cyc_o    (s_cyc_o),
    .s_stb_o    (s_stb_o),
    .s_we_o     (s_we_o),
    .s_adr_o    (s_adr_o),
    .s_dat_o    (s_dat_o),
    .s_sel_o    (s_sel_o),
    .s_dat_i    (s_dat_i),
    .s_ack_i    (s_ack_i),
    .s_stall_i  (s_stall_i),
    .gnt_o      (gnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entries are {master id, expected dat_o}.
  logic [16:0] sb[$];

  // Slave model: acks each accepted strobe exactly `lat` cycles later.
  int unsigned lat   = 1;
  logic [15:0] rdata = 16'h1234;
  logic [3:0]  ack_sr = '0;

  always @(posedge clk_i) begin
    if (s_cyc_o && s_stb_o && !s_stall_i) ack_sr <= (ack_sr >> 1) | (4'(1) << (lat - 1));
    else ack_sr <= ack_sr >> 1;
  end
  assign s_ack_i = ack_sr[0];
  assign s_dat_i = ack_sr[0] ? rdata : 16'h0000;

  always @(negedge clk_i) begin
    if (m0_ack_o || m1_ack_o) begin
      logic [16:0] act, exp_v;
      n_checks++;
      act = {m1_ack_o, m1_ack_o ? m1_dat_o : m0_dat_o};
      if (m0_ack_o && m1_ack_o) begin
        n_fail++;
        $display("FAIL ack_both: m0_ack=1 m1_ack=1, required at most one at t=%0t", $time);
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL ack_unexpected: got ack {m,dat}=%h, required none at t=%0t", act, $time);
      end else begin
        exp_v = sb.pop_front();
        if (act !== exp_v) begin
          n_fail++;
          $display("FAIL ack_data: got {m,dat}=%h, required %h at t=%0t", act, exp_v, $time);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at t=%0t", name, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_stb(input bit m, input bit stb, input bit we, input logic [3:1] adr,
                           input logic [15:0] dat);
    if (m) begin
      m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = 2'b11;
    end else begin
      m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = 2'b11;
    end
  endtask

  // Holds STB until n strobes are accepted; counts stalled cycles.
  task automatic run_strobes(input bit m, input int n, input bit we, input logic [3:1] adr,
                             input logic [15:0] dat, input bit exp_ack, output int stalls);
    int sent = 0;
    int guard = 0;
    stalls = 0;
    drive_stb(m, 1'b1, we, adr, dat);
    while (sent < n && guard < 50) begin
      @(negedge clk_i);
      if (!(m ? m1_stall_o : m0_stall_o)) begin
        sent++;
        if (exp_ack) sb.push_back({m, rdata});
      end else begin
        stalls++;
      end
      guard++;
      tick();
    end
    drive_stb(m, 1'b0, 1'b0, 3'd0, 16'h0000);
    check("strobes_accepted", 32'(sent), 32'(n));
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  initial begin
    int stalls;
    do_reset();

    // Reset state
    @(negedge clk_i);
    check("rst_gnt", 32'(gnt_o), 32'h0);
    check("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    check("rst_s_stb", 32'(s_stb_o), 32'h0);
    check("rst_m0_stall", 32'(m0_stall_o), 32'h1);
    check("rst_m1_stall", 32'(m1_stall_o), 32'h1);
    check("rst_m0_dat", 32'(m0_dat_o), 32'h0);
    tick();

    // Single-master write to CONFIG, slave acks next cycle
    lat = 1; rdata = 16'h1234;
    m0_cyc_i = 1'b1;
    @(negedge clk_i);
    check("t1_s_cyc_latency", 32'(s_cyc_o), 32'h0);
    tick();
    drive_stb(1'b0, 1'b1, 1'b1, SiaAdrConfig, 16'h3F0F);
    @(negedge clk_i);
    check("t1_gnt", 32'(gnt_o), 32'h1);
    check("t1_s_cyc", 32'(s_cyc_o), 32'h1);
    check("t1_m0_stall", 32'(m0_stall_o), 32'h0);
    check("t1_m1_stall", 32'(m1_stall_o), 32'h1);
    check("t1_s_bus", {12'h0, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o}, {12'h0, 1'b1, 1'b1, SiaAdrConfig, 2'b11, 16'h3F0F});
    sb.push_back({1'b0, rdata});
    tick();
    drive_stb(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    @(negedge clk_i);
    check("t1_m0_ack", 32'(m0_ack_o), 32'h1);
    check("t1_m1_stall_ack", 32'(m1_stall_o), 32'h1);
    tick();
    m0_cyc_i = 1'b0;
    tick();
    @(negedge clk_i);
    check("t1_idle", 32'(gnt_o), 32'h0);
    tick();

    // Tie-break and alternation
    do_reset();
    m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
    tick();
    drive_stb(1'b1, 1'b1, 1'b0, 3'd7, 16'hFFFF);
    @(negedge clk_i);
    check("t2_first_tie_g0", 32'(gnt_o), 32'h1);
    check("t2_ng_stb_blocked", 32'(s_stb_o), 32'h0);
    check("t2_ng_stall", 32'(m1_stall_o), 32'h1);
    check("t2_ng_dat", 32'(m1_dat_o), 32'h0);
    tick();
    drive_stb(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
    m0_cyc_i = 1'b0;
    tick();
    @(negedge clk_i);
    check("t2_idle_gap", 32'(gnt_o), 32'h0);
    tick();
    @(negedge clk_i);
    check("t2_then_g1", 32'(gnt_o), 32'h2);
    tick();
    m1_cyc_i = 1'b0;
    tick();
    m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
    tick();
    @(negedge clk_i);
    check("t2_second_tie_g0", 32'(gnt_o), 32'h1);
    tick();
    m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
    tick();
    m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
    tick();
    @(negedge clk_i);
    check("t2_third_tie_g1", 32'(gnt_o), 32'h2);
    tick();
    m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
    tick();

    // Pipelined reads by m1, slave latency 2, limit 2
    lat = 2; rdata = 16'hABCD;
    m1_cyc_i = 1'b1;
    tick();
    run_strobes(1'b1, 3, 1'b0, SiaAdrData, 16'h0000, 1'b1, stalls);
    check("t3_stall_cycles", 32'(stalls), 32'd1);
    repeat (4) tick();
    @(negedge clk_i);
    check("t3_outst_zero", 32'(dut.outst), 32'h0);
    tick();
    m1_cyc_i = 1'b0;
    tick();

    // Abort with one transfer outstanding
    lat = 2; rdata = 16'h5A5A;
    m0_cyc_i = 1'b1;
    tick();
    run_strobes(1'b0, 1, 1'b0, SiaAdrStatus, 16'h0000, 1'b0, stalls);
    m0_cyc_i = 1'b0;
    @(negedge clk_i);
    check("t4_outst_before_abort", 32'(dut.outst), 32'h1);
    tick();
    @(negedge clk_i);
    check("t4_late_ack_m0", 32'(m0_ack_o), 32'h0);
    check("t4_late_ack_m1", 32'(m1_ack_o), 32'h0);
    check("t4_outst_cleared", 32'(dut.outst), 32'h0);
    tick();
    lat = 1; rdata = 16'h0F0F;
    m0_cyc_i = 1'b1;
    tick();
    run_strobes(1'b0, 3, 1'b0, SiaAdrStatus, 16'h0000, 1'b1, stalls);
    check("t4_fresh_no_stall", 32'(stalls), 32'd0);
    tick();
    m0_cyc_i = 1'b0;
    tick();

    // Reset mid-grant with one outstanding
    lat = 2; rdata = 16'h7777;
    m1_cyc_i = 1'b1;
    tick();
    run_strobes(1'b1, 1, 1'b0, SiaAdrData, 16'h0000, 1'b0, stalls);
    reset_i = 1'b1;
    m0_cyc_i = 1'b1;
    tick();
    reset_i = 1'b0;
    @(negedge clk_i);
    check("t5_gnt", 32'(gnt_o), 32'h0);
    check("t5_s_cyc", 32'(s_cyc_o), 32'h0);
    check("t5_stalls", {30'h0, m0_stall_o, m1_stall_o}, 32'h3);
    check("t5_outst", 32'(dut.outst), 32'h0);
    tick();
    @(negedge clk_i);
    check("t5_m0_wins", 32'(gnt_o), 32'h1);
    tick();
    m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
    tick();
    tick();

    // Non-granted master strobing while m0 transfers
    lat = 1; rdata = 16'h00C3;
    m0_cyc_i = 1'b1;
    tick();
    m1_cyc_i = 1'b1;
    drive_stb(1'b1, 1'b1, 1'b1, 3'd7, 16'hFFFF);
    @(negedge clk_i);
    check("t6_no_ng_stb", 32'(s_stb_o), 32'h0);
    check("t6_ng_stall", 32'(m1_stall_o), 32'h1);
    tick();
    run_strobes(1'b0, 2, 1'b1, SiaAdrCtrl, 16'h0055, 1'b1, stalls);
    tick();
    drive_stb(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
    m0_cyc_i = 1'b0;
    tick();
    tick();
    @(negedge clk_i);
    check("t6_m1_after", 32'(gnt_o), 32'h2);
    tick();
    m1_cyc_i = 1'b0;
    repeat (3) tick();

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
